// File: rtl/periph_bus_pkg.sv
// Shared types and limits for the peripheral bus offset decoders.
package periph_bus_pkg;

  localparam int MAX_REGS = 32;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STALL
  } periph_dec_state_t;

  // Error cause of a grant; kept as a type so status logging can reuse it.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_UNMAPPED,
    ERR_TIMEOUT
  } periph_err_t;

endpackage

// File: rtl/periph_wait_timer.sv
// Wait-state down-counter plus saturating stall counter for the offset decoder.
module periph_wait_timer #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 255,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              tick,
  input  logic              stall,
  output logic              wait_done,
  output logic              timeout
);

  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  // A load may coincide with the first stalled cycle (zero wait states).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else if (load) begin
      wait_cnt  <= load_val;
      stall_cnt <= stall ? CNT_W'(1) : '0;
    end else begin
      if (tick && wait_cnt != '0)
        wait_cnt <= wait_cnt - WAIT_W'(1);
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign wait_done = (wait_cnt <= WAIT_W'(1));
  assign timeout   = (stall_cnt >= CNT_W'(TIMEOUT));

endmodule

// File: rtl/periph_offset_decoder.sv
// Decodes bus offsets onto NUM_REGS word registers and drives gnt/rvalid,
// with optional wait states, ready back-pressure and an error timeout.
//
// state | meaning
// IDLE  | no transaction held; decode and grant zero-latency hits/misses
// WAIT  | accepted hit counting down wait states
// STALL | wait done, holding for reg_ready[idx] or the timeout
module periph_offset_decoder
  import periph_bus_pkg::*;
#(
  parameter int                     NUM_REGS    = 5,
  parameter int                     OFFSET_W    = 12,
  parameter logic [NUM_REGS*16-1:0] REG_OFFSETS = {16'h000, 16'h004, 16'h008, 16'h00c, 16'h010},
  parameter int                     WAIT_STATES = 0,
  parameter int                     TIMEOUT     = 255,
  localparam int                    IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [NUM_REGS-1:0] reg_ready,
  output logic                gnt,
  output logic                rvalid,
  output logic                err,
  output logic [NUM_REGS-1:0] sel,
  output logic [IDX_W-1:0]    sel_idx,
  output logic                wr_stb,
  output logic                rd_stb
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  periph_dec_state_t state_q, state_d;
  periph_err_t       err_kind;
  logic [IDX_W-1:0]  idx_q, dec_idx, g_idx;
  logic              we_q, g_we, dec_hit, gnt_c, ok_grant;
  logic              wt_load, wt_tick, wt_stall, wait_done, timeout;
  logic              unused_addr;

  assign unused_addr = ^addr[31:OFFSET_W];

  // Entry 0 is the leftmost field of REG_OFFSETS; descending scan lets the lowest index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (addr[OFFSET_W-1:0] == REG_OFFSETS[(NUM_REGS-1-i)*16 +: OFFSET_W] &&
          addr[1:0] == 2'b00) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_c    = 1'b0;
    err_kind = ERR_NONE;
    wt_load  = 1'b0;
    wt_tick  = 1'b0;
    wt_stall = 1'b0;
    g_idx    = (state_q == IDLE) ? dec_idx : idx_q;
    g_we     = (state_q == IDLE) ? we : we_q;
    case (state_q)
      IDLE: if (req) begin
        if (!dec_hit) begin
          gnt_c    = 1'b1;
          err_kind = ERR_UNMAPPED;
        end else if (WAIT_STATES == 0 && reg_ready[dec_idx]) begin
          gnt_c = 1'b1;
        end else begin
          // With no wait states the acceptance cycle is already a stalled cycle.
          wt_load  = 1'b1;
          wt_stall = (WAIT_STATES == 0);
          state_d  = (WAIT_STATES == 0) ? STALL : WAIT;
        end
      end
      WAIT: if (!req) begin
        state_d = IDLE;
      end else begin
        wt_tick = 1'b1;
        if (wait_done) begin
          if (reg_ready[idx_q]) begin
            gnt_c = 1'b1;
          end else begin
            wt_stall = 1'b1;
            state_d  = STALL;
          end
        end
      end
      STALL: if (!req) begin
        state_d = IDLE;
      end else if (reg_ready[idx_q]) begin
        gnt_c = 1'b1;
      end else if (timeout) begin
        gnt_c    = 1'b1;
        err_kind = ERR_TIMEOUT;
      end else begin
        wt_stall = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (gnt_c)
      state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        idx_q <= dec_idx;
        we_q  <= we;
      end
      rvalid <= gnt;
      err    <= gnt & (err_kind != ERR_NONE);
    end
  end

  periph_wait_timer #(
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (wt_load),
    .load_val  (WAIT_W'(WAIT_STATES)),
    .tick      (wt_tick),
    .stall     (wt_stall),
    .wait_done (wait_done),
    .timeout   (timeout)
  );

  assign gnt      = gnt_c & ~rst;
  assign ok_grant = gnt & (err_kind == ERR_NONE);
  assign sel_idx  = ok_grant ? g_idx : '0;
  assign wr_stb   = ok_grant & g_we;
  assign rd_stb   = ok_grant & ~g_we;

  always_comb begin
    sel = '0;
    if (ok_grant)
      sel[g_idx] = 1'b1;
  end

endmodule
